// File: rtl/digital_signal_measure_multi.sv
// rtl/digital_signal_measure_multi.sv - per-channel pulse high/low/period measurement with averaging
// Each channel: 3-flop synchroniser, edge-driven FSM, saturating counters, accumulators and idle timeout.
module digital_signal_measure_multi #(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CH_NUM-1:0]           measure_pin,
    input  logic [CH_NUM-1:0]           measure_start,
    input  logic                        continuous,
    input  logic [CNT_W-1:0]            timeout_cycles,
    output logic [CH_NUM*CNT_W-1:0]     high_time,
    output logic [CH_NUM*CNT_W-1:0]     low_time,
    output logic [CH_NUM*(CNT_W+1)-1:0] period,
    output logic [CH_NUM-1:0]           measure_done,
    output logic [CH_NUM-1:0]           busy,
    output logic [CH_NUM-1:0]           overflow,
    output logic [CH_NUM-1:0]           timeout
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_RISE = 2'd1;
    localparam logic [1:0] S_MEAS_HIGH = 2'd2;
    localparam logic [1:0] S_MEAS_LOW  = 2'd3;

    localparam int AH_W  = CNT_W + AVG_LOG2;
    localparam int AP_W  = CNT_W + 1 + AVG_LOG2;
    localparam int IDX_W = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(1) << AVG_LOG2;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic             sync1_q, sync2_q, sync3_q;
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
        logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
        logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
        logic [AH_W-1:0]  acc_high_q, acc_high_d;
        logic [AH_W-1:0]  acc_low_q, acc_low_d;
        logic [AP_W-1:0]  acc_per_q, acc_per_d;
        logic [IDX_W-1:0] idx_q, idx_d;
        logic [CNT_W-1:0] high_out_q, high_out_d;
        logic [CNT_W-1:0] low_out_q, low_out_d;
        logic [CNT_W:0]   per_out_q, per_out_d;
        logic             done_q, done_d;
        logic             ovf_q, ovf_d;
        logic             tmo_q, tmo_d;
        logic             rise, fall, tmo_hit, last_period;
        logic [AH_W-1:0]  sum_high, sum_low;
        logic [AP_W-1:0]  sum_per;

        assign rise        = sync2_q & ~sync3_q;
        assign fall        = ~sync2_q & sync3_q;
        assign sum_high    = acc_high_q + AH_W'(high_cnt_q);
        assign sum_low     = acc_low_q + AH_W'(low_cnt_q);
        assign sum_per     = acc_per_q + AP_W'(high_cnt_q) + AP_W'(low_cnt_q);
        assign last_period = (idx_q + IDX_W'(1)) == IDX_END;
        // An edge in the matching cycle restarts the idle count, so it suppresses the timeout.
        assign tmo_hit     = (timeout_cycles != '0) && (idle_cnt_q == timeout_cycles) && !(rise || fall);

        always_comb begin
            state_d    = state_q;
            high_cnt_d = high_cnt_q;
            low_cnt_d  = low_cnt_q;
            acc_high_d = acc_high_q;
            acc_low_d  = acc_low_q;
            acc_per_d  = acc_per_q;
            idx_d      = idx_q;
            high_out_d = high_out_q;
            low_out_d  = low_out_q;
            per_out_d  = per_out_q;
            ovf_d      = ovf_q;
            tmo_d      = tmo_q;
            done_d     = 1'b0;

            if (state_q == S_IDLE || rise || fall) begin
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_ONE;
            end

            case (state_q)
                S_IDLE: begin
                    if (measure_start[c]) begin
                        acc_high_d = '0;
                        acc_low_d  = '0;
                        acc_per_d  = '0;
                        idx_d      = '0;
                        ovf_d      = 1'b0;
                        tmo_d      = 1'b0;
                        state_d    = S_WAIT_RISE;
                    end
                end
                S_WAIT_RISE: begin
                    if (rise) begin
                        high_cnt_d = CNT_ONE;
                        state_d    = S_MEAS_HIGH;
                    end
                end
                S_MEAS_HIGH: begin
                    if (fall) begin
                        low_cnt_d = CNT_ONE;
                        state_d   = S_MEAS_LOW;
                    end else begin
                        if (high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_ONE;
                        if (high_cnt_q >= CNT_MAX - CNT_ONE) ovf_d = 1'b1;
                    end
                end
                default: begin
                    if (rise) begin
                        high_cnt_d = CNT_ONE;
                        if (last_period) begin
                            high_out_d = sum_high[AVG_LOG2 +: CNT_W];
                            low_out_d  = sum_low[AVG_LOG2 +: CNT_W];
                            per_out_d  = sum_per[AVG_LOG2 +: CNT_W+1];
                            done_d     = 1'b1;
                            acc_high_d = '0;
                            acc_low_d  = '0;
                            acc_per_d  = '0;
                            idx_d      = '0;
                            state_d    = continuous ? S_MEAS_HIGH : S_IDLE;
                        end else begin
                            acc_high_d = sum_high;
                            acc_low_d  = sum_low;
                            acc_per_d  = sum_per;
                            idx_d      = idx_q + IDX_W'(1);
                            state_d    = S_MEAS_HIGH;
                        end
                    end else begin
                        if (low_cnt_q != CNT_MAX) low_cnt_d = low_cnt_q + CNT_ONE;
                        if (low_cnt_q >= CNT_MAX - CNT_ONE) ovf_d = 1'b1;
                    end
                end
            endcase

            if (state_q != S_IDLE && tmo_hit) begin
                state_d = S_IDLE;
                tmo_d   = 1'b1;
                done_d  = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                sync3_q    <= 1'b0;
                state_q    <= S_IDLE;
                high_cnt_q <= '0;
                low_cnt_q  <= '0;
                idle_cnt_q <= '0;
                acc_high_q <= '0;
                acc_low_q  <= '0;
                acc_per_q  <= '0;
                idx_q      <= '0;
                high_out_q <= '0;
                low_out_q  <= '0;
                per_out_q  <= '0;
                done_q     <= 1'b0;
                ovf_q      <= 1'b0;
                tmo_q      <= 1'b0;
            end else begin
                sync1_q    <= measure_pin[c];
                sync2_q    <= sync1_q;
                sync3_q    <= sync2_q;
                state_q    <= state_d;
                high_cnt_q <= high_cnt_d;
                low_cnt_q  <= low_cnt_d;
                idle_cnt_q <= idle_cnt_d;
                acc_high_q <= acc_high_d;
                acc_low_q  <= acc_low_d;
                acc_per_q  <= acc_per_d;
                idx_q      <= idx_d;
                high_out_q <= high_out_d;
                low_out_q  <= low_out_d;
                per_out_q  <= per_out_d;
                done_q     <= done_d;
                ovf_q      <= ovf_d;
                tmo_q      <= tmo_d;
            end
        end

        assign high_time[c*CNT_W +: CNT_W]     = high_out_q;
        assign low_time[c*CNT_W +: CNT_W]      = low_out_q;
        assign period[c*(CNT_W+1) +: CNT_W+1]  = per_out_q;
        assign measure_done[c]                 = done_q;
        assign busy[c]                         = (state_q != S_IDLE);
        assign overflow[c]                     = ovf_q;
        assign timeout[c]                      = tmo_q;
    end

endmodule

// File: tb/tb_digital_signal_measure_multi.sv
// tb/tb_digital_signal_measure_multi.sv - directed bench with result scoreboard
// Three instances: 4ch/16b/no averaging, 1ch/16b/4-period averaging, 1ch/8b for saturation.
module tb_digital_signal_measure_multi;

    logic        clk;
    logic        rst;

    logic [3:0]  pin_dir, gen_pins, pin_a, start_a;
    logic        cont_a, gen_en;
    logic [15:0] tmo_cyc_a;
    logic [63:0] high_a, low_a;
    logic [67:0] per_a;
    logic [3:0]  done_a, busy_a, ovf_a, tmo_a;

    logic [0:0]  pin_b, start_b, done_b, busy_b, ovf_b, tmo_b;
    logic [15:0] high_b, low_b;
    logic [16:0] per_b;

    logic [0:0]  pin_c, start_c, done_c, busy_c, ovf_c, tmo_c;
    logic [7:0]  high_c, low_c;
    logic [8:0]  per_c;

    assign pin_a = gen_en ? gen_pins : pin_dir;

    digital_signal_measure_multi #(.CH_NUM(4), .CNT_W(16), .AVG_LOG2(0)) dut_a (
        .clk(clk), .rst(rst), .measure_pin(pin_a), .measure_start(start_a),
        .continuous(cont_a), .timeout_cycles(tmo_cyc_a),
        .high_time(high_a), .low_time(low_a), .period(per_a),
        .measure_done(done_a), .busy(busy_a), .overflow(ovf_a), .timeout(tmo_a));

    digital_signal_measure_multi #(.CH_NUM(1), .CNT_W(16), .AVG_LOG2(2)) dut_b (
        .clk(clk), .rst(rst), .measure_pin(pin_b), .measure_start(start_b),
        .continuous(1'b0), .timeout_cycles(16'd0),
        .high_time(high_b), .low_time(low_b), .period(per_b),
        .measure_done(done_b), .busy(busy_b), .overflow(ovf_b), .timeout(tmo_b));

    digital_signal_measure_multi #(.CH_NUM(1), .CNT_W(8), .AVG_LOG2(0)) dut_c (
        .clk(clk), .rst(rst), .measure_pin(pin_c), .measure_start(start_c),
        .continuous(1'b0), .timeout_cycles(8'd0),
        .high_time(high_c), .low_time(low_c), .period(per_c),
        .measure_done(done_c), .busy(busy_c), .overflow(ovf_c), .timeout(tmo_c));

    typedef struct {
        int s;
        int h;
        int l;
        int p;
        int o;
        int t;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt[6];
    int   snap[4];
    bit   cont_mode = 1'b0;
    int   gcnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running 50% duty generator: channel c toggles every 4*(c+1) cycles.
    initial begin
        gen_pins = '0;
        forever begin
            @(posedge clk);
            #1;
            gcnt++;
            for (int c = 0; c < 4; c++) gen_pins[c] = ((gcnt / (4 * (c + 1))) % 2) == 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int s, input int h, input int l, input int p, input int o, input int t);
        exp_t e;
        e.s = s; e.h = h; e.l = l; e.p = p; e.o = o; e.t = t;
        sb.push_back(e);
    endtask

    function automatic int pending(input int s);
        int n = 0;
        foreach (sb[i]) if (sb[i].s == s) n++;
        return n;
    endfunction

    function automatic void get_obs(input int s, output int h, output int l, output int p,
                                    output int o, output int t);
        if (s < 4) begin
            h = int'(high_a[s*16 +: 16]);
            l = int'(low_a[s*16 +: 16]);
            p = int'(per_a[s*17 +: 17]);
            o = int'(ovf_a[s]);
            t = int'(tmo_a[s]);
        end else if (s == 4) begin
            h = int'(high_b); l = int'(low_b); p = int'(per_b);
            o = int'(ovf_b);  t = int'(tmo_b);
        end else begin
            h = int'(high_c); l = int'(low_c); p = int'(per_c);
            o = int'(ovf_c);  t = int'(tmo_c);
        end
    endfunction

    always @(negedge clk) begin
        logic [5:0] dv;
        int oh, ol, op, oo, ot, idx, hh;
        dv = {done_c, done_b, done_a};
        for (int s = 0; s < 6; s++) begin
            if (dv[s]) begin
                done_cnt[s]++;
                get_obs(s, oh, ol, op, oo, ot);
                if (s < 4 && cont_mode) begin
                    hh = 4 * (s + 1);
                    check($sformatf("cont_high_ch%0d", s), oh, hh);
                    check($sformatf("cont_low_ch%0d", s), ol, hh);
                    check($sformatf("cont_period_ch%0d", s), op, 2 * hh);
                    check($sformatf("cont_flags_ch%0d", s), oo + ot, 0);
                end else begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].s == s) idx = i;
                    end
                    if (idx < 0) begin
                        check($sformatf("unexpected_done_s%0d", s), 1, 0);
                    end else begin
                        check($sformatf("high_s%0d", s), oh, sb[idx].h);
                        check($sformatf("low_s%0d", s), ol, sb[idx].l);
                        check($sformatf("period_s%0d", s), op, sb[idx].p);
                        check($sformatf("overflow_s%0d", s), oo, sb[idx].o);
                        check($sformatf("timeout_s%0d", s), ot, sb[idx].t);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic hold(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int s, input int budget);
        int n = 0;
        while (pending(s) != 0 && n < budget) begin
            hold(1);
            n++;
        end
        check($sformatf("drain_s%0d", s), pending(s), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        pin_dir = '0; start_a = '0; cont_a = 1'b0; gen_en = 1'b0; tmo_cyc_a = '0;
        pin_b = '0; start_b = '0; pin_c = '0; start_c = '0;
        for (int s = 0; s < 6; s++) done_cnt[s] = 0;
        hold(3);

        check("reset_high_a", int'(|high_a), 0);
        check("reset_low_a", int'(|low_a), 0);
        check("reset_period_a", int'(|per_a), 0);
        check("reset_flags_a", int'({done_a, busy_a, ovf_a, tmo_a}), 0);
        rst = 1'b0;
        hold(2);

        // Single period 10 high / 30 low on channel 0
        push(0, 10, 30, 40, 0, 0);
        start_a[0] = 1'b1; hold(1); start_a[0] = 1'b0;
        check("busy_after_start", int'(busy_a[0]), 1);
        pin_dir[0] = 1'b1; hold(10);
        pin_dir[0] = 1'b0; hold(30);
        pin_dir[0] = 1'b1; hold(5);
        drain(0, 50);
        hold(2);
        check("busy_after_single", int'(busy_a[0]), 0);
        check("single_done_count", done_cnt[0], 1);

        // Stuck-low pin with a 100-cycle timeout keeps the previous result
        pin_dir[0] = 1'b0; hold(5);
        tmo_cyc_a = 16'd100;
        push(0, 10, 30, 40, 0, 1);
        start_a[0] = 1'b1; hold(1); start_a[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a[0] && n < 150);
        check("timeout_latency_ok", int'(n >= 101 && n <= 102), 1);
        check("timeout_busy_low", int'(busy_a[0]), 0);
        hold(1);
        tmo_cyc_a = 16'd0;
        check("timeout_sticky", int'(tmo_a[0]), 1);
        push(0, 6, 9, 15, 0, 0);
        start_a[0] = 1'b1; hold(1); start_a[0] = 1'b0;
        check("timeout_cleared_by_start", int'(tmo_a[0]), 0);
        pin_dir[0] = 1'b1; hold(6);
        pin_dir[0] = 1'b0; hold(9);
        pin_dir[0] = 1'b1; hold(5);
        drain(0, 50);

        // Four-period average: highs 10,12,10,13 with lows of 20
        push(4, 11, 20, 31, 0, 0);
        start_b = 1'b1; hold(1); start_b = 1'b0;
        pin_b = 1'b1; hold(10); pin_b = 1'b0; hold(20);
        pin_b = 1'b1; hold(12); pin_b = 1'b0; hold(20);
        pin_b = 1'b1; hold(10); pin_b = 1'b0; hold(20);
        pin_b = 1'b1; hold(13); pin_b = 1'b0; hold(20);
        pin_b = 1'b1; hold(5);
        drain(4, 50);
        hold(2);
        check("avg_done_count", done_cnt[4], 1);
        check("avg_busy_low", int'(busy_b), 0);

        // 8-bit counter saturation on a 300-cycle high phase
        push(5, 255, 5, 260, 1, 0);
        start_c = 1'b1; hold(1); start_c = 1'b0;
        pin_c = 1'b1; hold(300);
        pin_c = 1'b0; hold(5);
        pin_c = 1'b1; hold(5);
        drain(5, 50);

        // Continuous mode on all four channels, then a single final result each
        pin_dir = '0;
        gen_en = 1'b1;
        cont_mode = 1'b1;
        cont_a = 1'b1;
        hold(2);
        for (int c = 0; c < 4; c++) snap[c] = done_cnt[c];
        start_a = 4'hF; hold(1); start_a = 4'h0;
        hold(300);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("cont_results_ch%0d", c), int'(done_cnt[c] - snap[c] >= 3), 1);
        end
        @(negedge clk);
        #1;
        cont_a = 1'b0;
        for (int c = 0; c < 4; c++) snap[c] = done_cnt[c];
        hold(120);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("final_result_ch%0d", c), done_cnt[c] - snap[c], 1);
            check($sformatf("final_busy_ch%0d", c), int'(busy_a[c]), 0);
        end
        cont_mode = 1'b0;
        gen_en = 1'b0;
        hold(5);

        // Reset while channel 0 is in its low phase
        start_a[0] = 1'b1; hold(1); start_a[0] = 1'b0;
        pin_dir[0] = 1'b1; hold(10);
        pin_dir[0] = 1'b0; hold(5);
        rst = 1'b1; hold(1);
        check("midrst_high_a", int'(|high_a), 0);
        check("midrst_low_a", int'(|low_a), 0);
        check("midrst_period_a", int'(|per_a), 0);
        check("midrst_flags_a", int'({done_a, busy_a, ovf_a, tmo_a}), 0);
        check("midrst_other", int'(|{high_b, per_b, high_c, per_c, ovf_c}), 0);
        rst = 1'b0;
        n = done_cnt[0];
        pin_dir[0] = 1'b1; hold(5);
        pin_dir[0] = 1'b0; hold(5);
        check("midrst_no_done", done_cnt[0] - n, 0);
        push(0, 7, 11, 18, 0, 0);
        start_a[0] = 1'b1; hold(1); start_a[0] = 1'b0;
        pin_dir[0] = 1'b1; hold(7);
        pin_dir[0] = 1'b0; hold(11);
        pin_dir[0] = 1'b1; hold(5);
        drain(0, 50);

        hold(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
